spi_gpio_bridge: RTL and testbench
==================================

# spi_gpio_bridge

SPI-slave register bridge that exposes `NPORT` 8-bit bidirectional GPIO ports, per-port change-interrupt logic and an ID register to an external SPI master. It generalises the single-port SPI-to-GPIO block in width (1..8 ports) and adds multi-byte burst transfers with address auto-increment, input-change interrupts with mask and write-1-to-clear status, and defined abort behaviour. It sits at the chip top between the SPI pins and the GPIO pads.

## Interface
- `NPORT`, 2: number of 8-bit GPIO ports, legal range 1..8.
- `ID_VALUE`, 8'hA5: value returned from the ID register at 0x3F.
- `clk`  in  1  system clock; all logic is in this single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `spi_clk`  in  1  SPI SCK, mode 0 (CPOL=0, CPHA=0); asynchronous to `clk`.
- `spi_fss`  in  1  SPI chip select, active low.
- `spi_in`  in  1  MOSI.
- `spi_out`  out  1  MISO; Z while `spi_fss`=1.
- `gport`  inout  8*NPORT  GPIO pads; port p is bits [8p+7:8p].
- `irq`  out  1  level interrupt, high while any masked status bit is set.

## Operation
- SPI inputs pass through 2-FF synchronizers; the SCK rising edge is detected on the synchronized signal. Bits are shifted MSB first; MOSI is sampled on the rising edge, and MISO = shift register bit 7.
- Frame: the first byte after `spi_fss` falls is the command: bit7 = 1 write / 0 read, bit6 = auto-increment (AI), bits[5:0] = address. All following bytes are data until `spi_fss` rises.
- Write frame: each data byte is written to the current address. With AI=1 the address then increments by 1 modulo 64 (0x3F wraps to 0x00). With AI=0 the address is held.
- Read frame: at the end of the command byte, reg[addr] is loaded into the shift register and shifted out during data byte 1. At the end of each data byte, the address advances if AI=1, and the next reg value is loaded. MOSI content of read data bytes is ignored.
- MISO during the command byte and during all write-frame bytes is 0x5A.
- Register map, per port p (0 ≤ p < NPORT):
  - 4p+0 OE, RW: bit = 1 drives the pad.
  - 4p+1 ODATA, RW.
  - 4p+2 IDATA, RO: synchronized pad value, snapshotted at load time.
  - 4p+3 MASK, RW.
  - 0x20+p STATUS: bits set on any change of the synchronized input bit; write 1 to clear.
  - 0x3F ID, RO.
- Unmapped or out-of-range addresses (including ports ≥ NPORT) read as 0x00. Writes to them and to RO registers are ignored.
- GPIO inputs use 2-FF synchronizers plus one history register for change detection. Change detection operates regardless of OE.
- `irq` = OR over p of (STATUS[p] & MASK[p]), registered.

## Timing
- Reset values:
  - OE, ODATA, MASK and STATUS are 0x00, so all pads are Z.
  - The shift register is loaded with 0x5A and the bit counter is 0.
  - The frame state is CMD and the address is 0.
  - `irq` = 0.
  - `spi_out` = Z if `spi_fss`=1, else 0 (the MSB of 0x5A).
- Frame FSM: IDLE → (synced fss low) CMD → (8th rising SCK) WDATA or RDATA → stays in WDATA/RDATA per byte → (synced fss high) IDLE.
- Byte completion at clk cycle N, counted from the synced 8th rising edge:
  - The register write happens at N+1.
  - The shift register reload (read data or 0x5A) happens at N+2.
  - The master must therefore run SCK ≤ clk/8.
- `spi_fss` rising mid-byte: the partial byte is discarded, no write occurs, and the FSM returns to IDLE. The next frame starts with a command byte.
- A STATUS set and a W1C in the same cycle on the same bit: set wins.
- An input change appears in STATUS 3 clk after the pad edge; `irq` follows 1 clk later.
- `rst` asserted mid-frame: all state returns to reset values on the next clk edge. The remainder of that frame is ignored until `spi_fss` has been seen high.

## Test plan
- Write frame 0x80 0xFF, then 0x81 0xA5 (NPORT=2) → `gport[7:0]` = 0xA5 driven; `gport[15:8]` remains Z.
- Burst write 0xC0 0x0F 0x03 0x00 0x00 0xF0 (AI) → port0 OE=0x0F, ODATA=0x03; port1 OE=0xF0. Read 0x40 + 5 dummy bytes → returns 0x0F 0x03 pin 0x00 0xF0, where pin is the port0 IDATA snapshot.
- Read with AI starting at 0x3F, 2 data bytes → MISO 0xA5 then 0x00 (OE of port 0 after reset); command byte returns 0x5A.
- Set MASK0=0x01, toggle `gport[0]` externally → STATUS0=0x01 and `irq`=1 within 4 clk. Write 0xA0 0x01 → STATUS0=0x00 and `irq`=0. Toggle the pin in the same cycle as the clear → STATUS0 stays 0x01.
- Raise `spi_fss` after 4 bits of a 0x81 0x55 write → ODATA unchanged. The following frame 0x81 0x55 writes normally.
- Assert `rst` during a burst write → all registers 0x00, `irq`=0, pads Z, and no further writes until a new frame.

Source files
------------

// File: rtl/spi_gpio_bridge_if.sv
// rtl/spi_gpio_bridge_if.sv - SPI master-to-slave pin bundle for the GPIO bridge
interface spi_gpio_bridge_if;
   logic spi_clk;
   logic spi_fss;
   logic spi_in;

   modport master (output spi_clk, output spi_fss, output spi_in);
   modport slave  (input spi_clk, input spi_fss, input spi_in);
endinterface

// File: rtl/spi_gpio_bridge.sv
// rtl/spi_gpio_bridge.sv - SPI-slave register bridge to NPORT 8-bit GPIO ports with change interrupts
module spi_gpio_bridge #(
   parameter int         NPORT    = 2,
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic                clk,
   input  logic                rst,
   spi_gpio_bridge_if.slave    spi,
   output wire                 spi_out,
   inout  wire [8*NPORT-1:0]   gport,
   output logic                irq
);
   typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA} state_t;
   localparam logic [7:0] FILL_BYTE = 8'h5A;

   logic [2:0] sck_sync;
   logic [1:0] fss_sync;
   logic [1:0] mosi_sync;
   logic       sck_rise, fss_s, mosi_s;

   state_t     state, state_nxt;
   logic       armed, frame_on, shift_en;
   logic       do_cmd, do_wr, do_rd;
   logic [7:0] sr;
   logic [2:0] bit_cnt;
   logic       byte_done, load_pend, load_rd;
   logic       cmd_ai;
   logic [5:0] addr;
   logic [7:0] rd_data;

   logic [7:0] oe [NPORT];
   logic [7:0] odata [NPORT];
   logic [7:0] mask [NPORT];
   logic [7:0] status [NPORT];
   logic [7:0] pin_s1 [NPORT];
   logic [7:0] pin_s2 [NPORT];
   logic [7:0] pin_h [NPORT];
   logic [NPORT-1:0] wr_oe, wr_odata, wr_mask, wr_w1c;
   logic       irq_any;

   // Synchronizers carry no reset so a reset never fabricates SCK edges or pin changes
   always_ff @(posedge clk) begin
      sck_sync  <= {sck_sync[1:0], spi.spi_clk};
      fss_sync  <= {fss_sync[0], spi.spi_fss};
      mosi_sync <= {mosi_sync[0], spi.spi_in};
   end

   assign sck_rise = sck_sync[1] & ~sck_sync[2];
   assign fss_s    = fss_sync[1];
   assign mosi_s   = mosi_sync[1];
   assign frame_on = armed & ~fss_s;
   assign spi_out  = spi.spi_fss ? 1'bz : sr[7];

   always_ff @(posedge clk) begin
      if (rst) state <= ST_CMD;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!fss_s) state_nxt = ST_CMD;
         ST_CMD:   if (fss_s) state_nxt = ST_IDLE;
                   else if (byte_done) state_nxt = sr[7] ? ST_WDATA : ST_RDATA;
         default:  if (fss_s) state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      shift_en = 1'b0;
      do_cmd   = 1'b0;
      do_wr    = 1'b0;
      do_rd    = 1'b0;
      case (state)
         ST_CMD:   begin shift_en = frame_on; do_cmd = byte_done; end
         ST_WDATA: begin shift_en = frame_on; do_wr  = byte_done; end
         ST_RDATA: begin shift_en = frame_on; do_rd  = byte_done; end
         default:  ;
      endcase
   end

   // armed stays low after reset until chip select is seen high, discarding a cut-off frame
   always_ff @(posedge clk) begin
      if (rst) begin
         armed     <= 1'b0;
         sr        <= FILL_BYTE;
         bit_cnt   <= 3'd0;
         byte_done <= 1'b0;
         load_pend <= 1'b0;
         load_rd   <= 1'b0;
      end else begin
         if (fss_s) armed <= 1'b1;
         byte_done <= 1'b0;
         load_pend <= do_cmd | do_wr | do_rd;
         load_rd   <= (do_cmd & ~sr[7]) | do_rd;
         if (!frame_on) begin
            sr        <= FILL_BYTE;
            bit_cnt   <= 3'd0;
            load_pend <= 1'b0;
         end else if (load_pend) begin
            sr <= load_rd ? rd_data : FILL_BYTE;
         end else if (shift_en && sck_rise) begin
            sr        <= {sr[6:0], mosi_s};
            bit_cnt   <= bit_cnt + 3'd1;
            byte_done <= (bit_cnt == 3'd7);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr   <= 6'd0;
         cmd_ai <= 1'b0;
      end else if (do_cmd) begin
         addr   <= sr[5:0];
         cmd_ai <= sr[6];
      end else if ((do_wr || do_rd) && cmd_ai) begin
         addr <= addr + 6'd1;
      end
   end

   always_comb begin
      wr_oe    = '0;
      wr_odata = '0;
      wr_mask  = '0;
      wr_w1c   = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (do_wr && !addr[5] && addr[4:2] == 3'(p)) begin
            wr_oe[p]    = (addr[1:0] == 2'd0);
            wr_odata[p] = (addr[1:0] == 2'd1);
            wr_mask[p]  = (addr[1:0] == 2'd3);
         end
         if (do_wr && addr[5:3] == 3'b100 && addr[2:0] == 3'(p)) wr_w1c[p] = 1'b1;
      end
   end

   always_comb begin
      rd_data = 8'h00;
      if (addr == 6'h3F) rd_data = ID_VALUE;
      for (int p = 0; p < NPORT; p++) begin
         if (!addr[5] && addr[4:2] == 3'(p)) begin
            case (addr[1:0])
               2'd0:    rd_data = oe[p];
               2'd1:    rd_data = odata[p];
               2'd2:    rd_data = pin_s2[p];
               default: rd_data = mask[p];
            endcase
         end
         if (addr[5:3] == 3'b100 && addr[2:0] == 3'(p)) rd_data = status[p];
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < NPORT; p++) begin
         pin_s1[p] <= gport[8*p +: 8];
         pin_s2[p] <= pin_s1[p];
         pin_h[p]  <= pin_s2[p];
      end
   end

   // A fresh input change overrides a simultaneous write-1-to-clear
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < NPORT; p++) begin
            oe[p]     <= 8'h00;
            odata[p]  <= 8'h00;
            mask[p]   <= 8'h00;
            status[p] <= 8'h00;
         end
      end else begin
         for (int p = 0; p < NPORT; p++) begin
            if (wr_oe[p])    oe[p]    <= sr;
            if (wr_odata[p]) odata[p] <= sr;
            if (wr_mask[p])  mask[p]  <= sr;
            status[p] <= (status[p] & ~(wr_w1c[p] ? sr : 8'h00)) | (pin_s2[p] ^ pin_h[p]);
         end
      end
   end

   always_comb begin
      irq_any = 1'b0;
      for (int p = 0; p < NPORT; p++) irq_any = irq_any | (|(status[p] & mask[p]));
   end

   always_ff @(posedge clk) begin
      if (rst) irq <= 1'b0;
      else     irq <= irq_any;
   end

   genvar gp, gb;
   generate
      for (gp = 0; gp < NPORT; gp++) begin : g_port
         for (gb = 0; gb < 8; gb++) begin : g_bit
            assign gport[8*gp+gb] = oe[gp][gb] ? odata[gp][gb] : 1'bz;
         end
      end
   endgenerate
endmodule

// File: tb/tb_spi_gpio_bridge.sv
// tb/tb_spi_gpio_bridge.sv - randomized self-checking bench for spi_gpio_bridge against a register-level model
module tb_spi_gpio_bridge;
   localparam int NPORT = 2;
   localparam int HALF  = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   wire  spi_out;
   wire  [8*NPORT-1:0] gport;
   logic irq;
   logic [8*NPORT-1:0] ext_en  = '0;
   logic [8*NPORT-1:0] ext_val = '0;

   spi_gpio_bridge_if spi_bus ();

   spi_gpio_bridge #(.NPORT(NPORT), .ID_VALUE(8'hA5)) dut (
      .clk     (clk),
      .rst     (rst),
      .spi     (spi_bus),
      .spi_out (spi_out),
      .gport   (gport),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   for (genvar i = 0; i < 8*NPORT; i++) begin : g_ext
      assign gport[i] = ext_en[i] ? ext_val[i] : 1'bz;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Register-level model: contents by address, pads as OE-selected mix of ODATA and external drive
   logic [7:0] m_oe [NPORT];
   logic [7:0] m_odata [NPORT];
   logic [7:0] m_mask [NPORT];

   task automatic model_reset();
      for (int p = 0; p < NPORT; p++) begin
         m_oe[p] = 8'h00; m_odata[p] = 8'h00; m_mask[p] = 8'h00;
      end
   endtask

   function automatic logic [7:0] pad_val(input int p);
      return (m_oe[p] & m_odata[p]) | (~m_oe[p] & ext_val[8*p +: 8]);
   endfunction

   function automatic logic [7:0] model_read(input int a, output bit skip);
      skip = 1'b0;
      if (a < 4*NPORT) begin
         if (a % 4 == 0)      return m_oe[a/4];
         else if (a % 4 == 1) return m_odata[a/4];
         else if (a % 4 == 2) return pad_val(a/4);
         else                 return m_mask[a/4];
      end
      if (a >= 32 && a < 32 + NPORT) begin
         skip = 1'b1;
         return 8'h00;
      end
      if (a == 63) return 8'hA5;
      return 8'h00;
   endfunction

   task automatic model_write(input int a, input logic [7:0] d);
      if (a < 4*NPORT) begin
         if (a % 4 == 0)      m_oe[a/4]    = d;
         else if (a % 4 == 1) m_odata[a/4] = d;
         else if (a % 4 == 3) m_mask[a/4]  = d;
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   logic [7:0] tx [16];
   logic [7:0] rx [16];

   task automatic spi_byte(input logic [7:0] d, input int nbits, input bit tog, output logic [7:0] q);
      q = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_bus.spi_in = d[i];
         tick(HALF);
         q[i] = spi_out;
         spi_bus.spi_clk = 1'b1;
         if (tog && i == 0) begin
            tick(1);
            ext_val[0] = ~ext_val[0];
            tick(HALF - 1);
         end else begin
            tick(HALF);
         end
         spi_bus.spi_clk = 1'b0;
      end
   endtask

   task automatic run_frame(input int n, input int tog_idx);
      spi_bus.spi_fss = 1'b0;
      tick(HALF);
      for (int i = 0; i < n; i++) spi_byte(tx[i], 8, (i == tog_idx), rx[i]);
      tick(HALF);
      spi_bus.spi_fss = 1'b1;
      tick(HALF);
   endtask

   task automatic do_frame(input string tag, input int n, input int tog_idx);
      logic [7:0] old_oe [NPORT];
      logic [7:0] e;
      bit wr, ai, skip;
      int a;
      wr = tx[0][7];
      ai = tx[0][6];
      a  = int'(tx[0][5:0]);
      old_oe = m_oe;
      if (wr) begin
         for (int i = 1; i < n; i++) begin
            model_write(a, tx[i]);
            if (ai) a = (a + 1) % 64;
         end
         for (int p = 0; p < NPORT; p++) ext_en[8*p +: 8] = ~(old_oe[p] | m_oe[p]);
      end
      run_frame(n, tog_idx);
      chk({tag, "_cmd"}, rx[0], 8'h5A);
      a = int'(tx[0][5:0]);
      for (int i = 1; i < n; i++) begin
         if (wr) begin
            chk({tag, "_wmiso"}, rx[i], 8'h5A);
         end else begin
            e = model_read(a, skip);
            if (!skip) chk({tag, "_rd"}, rx[i], e);
            if (ai) a = (a + 1) % 64;
         end
      end
      for (int p = 0; p < NPORT; p++) ext_en[8*p +: 8] = ~m_oe[p];
   endtask

   int         nb;
   logic [5:0] ra;
   logic [7:0] dummy;

   initial begin
      spi_bus.spi_clk = 1'b0;
      spi_bus.spi_fss = 1'b1;
      spi_bus.spi_in  = 1'b0;
      ext_val = {8'h3C, 8'($urandom) & 8'hFE};
      ext_en  = '1;
      model_reset();
      tick(4);
      rst = 1'b0;
      tick(4);

      chk("irq_rst", {7'd0, irq}, 8'h00);
      spi_bus.spi_fss = 1'b0;
      tick(1);
      chk("miso_rst", {7'd0, spi_out}, 8'h00);
      spi_bus.spi_fss = 1'b1;
      tick(HALF);

      tx[0] = 8'h40;
      for (int i = 1; i <= 4*NPORT; i++) tx[i] = 8'($urandom);
      do_frame("rst_regs", 4*NPORT + 1, -1);
      tx[0] = 8'h60; tx[1] = 8'h00; tx[2] = 8'h00;
      run_frame(3, -1);
      chk("rst_st0", rx[1], 8'h00);
      chk("rst_st1", rx[2], 8'h00);

      tx[0] = 8'h7F; tx[1] = 8'h00; tx[2] = 8'h00;
      do_frame("id_wrap", 3, -1);

      tx[0] = 8'h80; tx[1] = 8'hFF; do_frame("oe0", 2, -1);
      tx[0] = 8'h81; tx[1] = 8'hA5; do_frame("od0", 2, -1);
      chk("pad0_drv", gport[7:0], 8'hA5);
      chk("pad1_ext", gport[15:8], 8'h3C);

      tx[0] = 8'hC0; tx[1] = 8'h0F; tx[2] = 8'h03; tx[3] = 8'h00; tx[4] = 8'h00; tx[5] = 8'hF0;
      do_frame("burst_w", 6, -1);
      tx[0] = 8'h40;
      for (int i = 1; i <= 5; i++) tx[i] = 8'($urandom);
      do_frame("burst_r", 6, -1);

      tx[0] = 8'h80; tx[1] = 8'h00; do_frame("oe0_off", 2, -1);
      tx[0] = 8'h84; tx[1] = 8'h00; do_frame("oe1_off", 2, -1);
      tx[0] = 8'h83; tx[1] = 8'h01; do_frame("mask0", 2, -1);
      tx[0] = 8'hE0; tx[1] = 8'hFF; tx[2] = 8'hFF; do_frame("st_clr_all", 3, -1);
      tick(4);
      chk("irq_idle", {7'd0, irq}, 8'h00);

      ext_val[0] = ~ext_val[0];
      tick(3);
      chk("irq_early", {7'd0, irq}, 8'h00);
      tick(1);
      chk("irq_set", {7'd0, irq}, 8'h01);
      tx[0] = 8'h20; tx[1] = 8'h00; run_frame(2, -1);
      chk("st0_set", rx[1], 8'h01);

      tx[0] = 8'hA0; tx[1] = 8'h01; do_frame("w1c", 2, -1);
      tick(2);
      chk("irq_clr", {7'd0, irq}, 8'h00);
      tx[0] = 8'h20; tx[1] = 8'h00; run_frame(2, -1);
      chk("st0_clr", rx[1], 8'h00);

      ext_val[0] = ~ext_val[0];
      tick(6);
      tx[0] = 8'hA0; tx[1] = 8'h01; do_frame("w1c_race", 2, 1);
      tx[0] = 8'h20; tx[1] = 8'h00; run_frame(2, -1);
      chk("st0_race", rx[1], 8'h01);
      chk("irq_race", {7'd0, irq}, 8'h01);

      spi_bus.spi_fss = 1'b0;
      tick(HALF);
      spi_byte(8'h81, 8, 1'b0, rx[0]);
      spi_byte(8'h55, 4, 1'b0, dummy);
      tick(HALF);
      spi_bus.spi_fss = 1'b1;
      tick(HALF);
      chk("abort_cmd", rx[0], 8'h5A);
      tx[0] = 8'h01; tx[1] = 8'h00; do_frame("abort_od", 2, -1);
      tx[0] = 8'h81; tx[1] = 8'h55; do_frame("after_abort", 2, -1);
      tx[0] = 8'h01; tx[1] = 8'h00; do_frame("od_55", 2, -1);

      spi_bus.spi_fss = 1'b0;
      tick(HALF);
      spi_byte(8'hC1, 8, 1'b0, dummy);
      spi_byte(8'h12, 8, 1'b0, dummy);
      spi_byte(8'h34, 8, 1'b0, dummy);
      spi_byte(8'h56, 3, 1'b0, dummy);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      model_reset();
      spi_byte(8'h56 << 3, 5, 1'b0, dummy);
      spi_byte(8'h78, 8, 1'b0, dummy);
      spi_byte(8'h9A, 8, 1'b0, dummy);
      tick(HALF);
      spi_bus.spi_fss = 1'b1;
      tick(HALF);
      chk("irq_after_rst", {7'd0, irq}, 8'h00);
      chk("pad0_after_rst", gport[7:0], ext_val[7:0]);
      chk("pad1_after_rst", gport[15:8], ext_val[15:8]);
      tx[0] = 8'h40;
      for (int i = 1; i <= 4*NPORT; i++) tx[i] = 8'h00;
      do_frame("regs_after_rst", 4*NPORT + 1, -1);
      tx[0] = 8'h60; tx[1] = 8'h00; tx[2] = 8'h00;
      run_frame(3, -1);
      chk("st0_after_rst", rx[1], 8'h00);
      chk("st1_after_rst", rx[2], 8'h00);

      for (int it = 0; it < 24; it++) begin
         nb = int'($urandom_range(2, 5));
         case ($urandom_range(0, 3))
            0:       ra = 6'($urandom_range(0, 4*NPORT - 1));
            1:       ra = 6'($urandom_range(0, 63));
            2:       ra = 6'($urandom_range(62, 63));
            default: ra = 6'($urandom_range(4*NPORT, 4*NPORT + 3));
         endcase
         tx[0] = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra};
         for (int i = 1; i < nb; i++) tx[i] = 8'($urandom);
         if (!tx[0][7]) begin
            ext_val = (8*NPORT)'($urandom);
            tick(4);
         end
         do_frame("rnd", nb, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
